// File: rtl/din_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : din_pulse_conditioner
// Purpose  : Synchronizes an asynchronous raw level (button/sensor), debounces
//            it with a four-state FSM and emits one single-cycle din_pulse per
//            confirmed rising edge. Rejected transitions are counted in a
//            saturating glitch counter.
// Ports    : clk         - single clock, all flops on posedge
//            reset       - synchronous, active-high
//            raw_in      - asynchronous raw level
//            glitch_clr  - synchronous clear of glitch_cnt
//            din_pulse   - registered 1-cycle pulse per accepted rise
//            level_out   - registered debounced level
//            glitch_cnt  - 8-bit saturating count of rejected transitions
// Revision : 1.0 - initial release
// ============================================================================
module din_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_in,
  input  logic       glitch_clr,
  output logic       din_pulse,
  output logic       level_out,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_HIGH     = 2'd2,
    ST_FALL_CHK = 2'd3
  } state_t;

  // Count value at which one more matching sample completes the debounce
  // window (the sample that entered the check state counts as 1).
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [7:0]       c_gcnt_max = 8'hFF;

  logic             r_s1;
  logic             r_s2;
  logic             w_raw_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_glitch;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer; only the second stage is ever looked at.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= raw_in;
      r_s2 <= r_s1;
    end
  end

  assign w_raw_s = r_s2;

  // A glitch is a check state abandoned because the synced level went back
  // before the debounce window completed.
  assign w_glitch = ((r_state == ST_RISE_CHK) && !w_raw_s) ||
                    ((r_state == ST_FALL_CHK) &&  w_raw_s);

  // --------------------------------------------------------------------------
  // Debounce FSM with registered outputs. din_pulse defaults low every cycle
  // so it can only be high in the first cycle after RISE_CHK -> HIGH.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_LOW;
      r_cnt     <= '0;
      din_pulse <= 1'b0;
      level_out <= 1'b0;
    end else begin
      din_pulse <= 1'b0;
      case (r_state)
        ST_LOW: begin
          if (w_raw_s) begin
            r_state <= ST_RISE_CHK;
            r_cnt   <= c_cnt_one;
          end else begin
            r_cnt   <= '0;
          end
        end

        ST_RISE_CHK: begin
          if (!w_raw_s) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == c_cnt_last) begin
            r_state   <= ST_HIGH;
            r_cnt     <= '0;
            level_out <= 1'b1;
            din_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        ST_HIGH: begin
          if (!w_raw_s) begin
            r_state <= ST_FALL_CHK;
            r_cnt   <= c_cnt_one;
          end else begin
            r_cnt   <= '0;
          end
        end

        ST_FALL_CHK: begin
          if (w_raw_s) begin
            r_state <= ST_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == c_cnt_last) begin
            r_state   <= ST_LOW;
            r_cnt     <= '0;
            level_out <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        default: begin
          // Unreachable encodings fall back to a quiet LOW.
          r_state   <= ST_LOW;
          r_cnt     <= '0;
          level_out <= 1'b0;
          din_pulse <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Saturating glitch counter; a clear takes priority over a same-cycle
  // increment.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_cnt <= 8'h00;
    end else if (glitch_clr) begin
      glitch_cnt <= 8'h00;
    end else if (w_glitch && (glitch_cnt != c_gcnt_max)) begin
      glitch_cnt <= glitch_cnt + 8'h01;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_din_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_din_pulse_conditioner
// Purpose  : Self-checking bench for din_pulse_conditioner. The reference
//            model describes debouncing as run lengths of the two-cycle
//            delayed input compared against the current debounced level.
// Revision : 1.0 - initial release
// ============================================================================
module tb_din_pulse_conditioner;

  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic       raw_in;
  logic       glitch_clr;
  logic       din_pulse;
  logic       level_out;
  logic [7:0] glitch_cnt;

  int checks;
  int errors;

  // Reference model state
  logic [1:0] m_q;      // raw_in history: [0] last edge, [1] two edges ago
  logic       m_level;
  int         m_run;    // consecutive synced samples differing from m_level
  logic       m_pulse;
  int         m_gcnt;

  din_pulse_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .glitch_clr(glitch_clr),
    .din_pulse (din_pulse),
    .level_out (level_out),
    .glitch_cnt(glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic raw, input logic clr, input logic rst);
    logic raw_s;
    logic glitch;
    if (rst) begin
      m_q = 2'b00; m_level = 1'b0; m_run = 0; m_pulse = 1'b0; m_gcnt = 0;
    end else begin
      raw_s   = m_q[1];
      m_q     = {m_q[0], raw};
      m_pulse = 1'b0;
      glitch  = 1'b0;
      if (raw_s != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = raw_s;
          m_pulse = raw_s;
          m_run   = 0;
        end
      end else begin
        glitch = (m_run != 0);
        m_run  = 0;
      end
      if (clr)                        m_gcnt = 0;
      else if (glitch && m_gcnt < 255) m_gcnt++;
    end
  endtask

  // True when the coming edge will abandon a partial debounce window.
  function automatic bit glitch_next();
    return (m_q[1] == m_level) && (m_run != 0);
  endfunction

  // Drive one cycle of inputs, advance the model, settle past the edge.
  task automatic step(input logic raw, input logic clr, input logic rst);
    @(negedge clk);
    raw_in = raw; glitch_clr = clr; reset = rst;
    @(posedge clk);
    model_edge(raw, clr, rst);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    checks++; if (din_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", din_pulse); end
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL reset_level got %b exp 0", level_out); end
    checks++; if (glitch_cnt !== 8'h00) begin errors++; $display("FAIL reset_gcnt got %0d exp 0", glitch_cnt); end
    do_reset();
  endtask

  task automatic test_clean_press();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (din_pulse !== (i == 5)) begin errors++; $display("FAIL press_pulse edge %0d got %b exp %b", i, din_pulse, (i == 5)); end
      checks++;
      if (level_out !== (i >= 5)) begin errors++; $display("FAIL press_level edge %0d got %b exp %b", i, level_out, (i >= 5)); end
    end
    checks++; if (glitch_cnt !== 8'h00) begin errors++; $display("FAIL press_gcnt got %0d exp 0", glitch_cnt); end
    // Falling: level drops D+1 edges after the first low sample.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (level_out !== (i < 5)) begin errors++; $display("FAIL fall_level edge %0d got %b exp %b", i, level_out, (i < 5)); end
      checks++;
      if (din_pulse !== 1'b0) begin errors++; $display("FAIL fall_pulse edge %0d got %b exp 0", i, din_pulse); end
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (din_pulse === 1'b1) pulses++;
      checks++;
      if (level_out !== 1'b0) begin errors++; $display("FAIL glitch_level cyc %0d got %b exp 0", i, level_out); end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL glitch_pulses got %0d exp 0", pulses); end
    checks++; if (glitch_cnt !== 8'd1) begin errors++; $display("FAIL glitch_gcnt got %0d exp 1", glitch_cnt); end
    step(1'b0, 1'b1, 1'b0);
    checks++; if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL glitch_clr got %0d exp 0", glitch_cnt); end
  endtask

  task automatic test_bounce();
    bit press_pat [0:8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit rel_pat   [0:5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(press_pat[i], 1'b0, 1'b0);
      if (din_pulse === 1'b1) pulses++;
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (din_pulse === 1'b1) pulses++;
    end
    checks++; if (level_out !== 1'b1) begin errors++; $display("FAIL bounce_level_hi got %b exp 1", level_out); end
    checks++; if (glitch_cnt !== 8'd2) begin errors++; $display("FAIL bounce_press_gcnt got %0d exp 2", glitch_cnt); end
    for (int i = 0; i < 6; i++) begin
      step(rel_pat[i], 1'b0, 1'b0);
      if (din_pulse === 1'b1) pulses++;
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (din_pulse === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL bounce_pulses got %0d exp 1", pulses); end
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL bounce_level_lo got %b exp 0", level_out); end
    // Two press bounces plus three release bounces.
    checks++; if (glitch_cnt !== 8'd5) begin errors++; $display("FAIL bounce_total_gcnt got %0d exp 5", glitch_cnt); end
  endtask

  task automatic test_saturation();
    logic v;
    bit   done;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++; if (glitch_cnt !== 8'd255) begin errors++; $display("FAIL sat_gcnt got %0d exp 255", glitch_cnt); end
    v = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 12 && !done; t++) begin
      if (glitch_next()) begin
        step(v, 1'b1, 1'b0);
        done = 1'b1;
        checks++; if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL sat_clr_vs_glitch got %0d exp 0", glitch_cnt); end
      end else begin
        step(v, 1'b0, 1'b0);
      end
      v = ~v;
    end
    checks++; if (!done) begin errors++; $display("FAIL sat_clr_setup got 0 exp 1"); end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);  // RISE_CHK, cnt=2
    step(1'b1, 1'b0, 1'b1);
    checks++; if (din_pulse !== 1'b0) begin errors++; $display("FAIL rstmid_pulse got %b exp 0", din_pulse); end
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL rstmid_level got %b exp 0", level_out); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (din_pulse !== (i == 5)) begin errors++; $display("FAIL rstmid_repulse edge %0d got %b exp %b", i, din_pulse, (i == 5)); end
    end
    checks++; if (level_out !== 1'b1) begin errors++; $display("FAIL rstmid_level_hi got %b exp 1", level_out); end
  endtask

  task automatic test_chain();
    int   pulses;
    logic prev;
    logic [1:0] ctr;
    pulses = 0; prev = 1'b0; ctr = 2'b00;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 20; i++) begin
        step((i < 10), 1'b0, 1'b0);
        if (din_pulse === 1'b1) begin pulses++; ctr = ctr + 2'b01; end
        checks++;
        if (prev && din_pulse) begin errors++; $display("FAIL chain_double_pulse press %0d got 1 exp 0", p); end
        prev = din_pulse;
      end
    end
    checks++; if (pulses != 5) begin errors++; $display("FAIL chain_pulses got %0d exp 5", pulses); end
    checks++; if (ctr !== 2'b01) begin errors++; $display("FAIL chain_counter got %b exp 01", ctr); end
  endtask

  task automatic test_random();
    logic v;
    logic prev;
    int   len;
    prev = 1'b0;
    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      for (int k = 0; k < len; k++) begin
        step(v, ($urandom_range(0, 29) == 0), ($urandom_range(0, 199) == 0));
        checks++;
        if (din_pulse !== m_pulse) begin errors++; $display("FAIL rand_pulse seg %0d got %b exp %b", seg, din_pulse, m_pulse); end
        checks++;
        if (level_out !== m_level) begin errors++; $display("FAIL rand_level seg %0d got %b exp %b", seg, level_out, m_level); end
        checks++;
        if (glitch_cnt !== 8'(m_gcnt)) begin errors++; $display("FAIL rand_gcnt seg %0d got %0d exp %0d", seg, glitch_cnt, m_gcnt); end
        checks++;
        if (prev && din_pulse) begin errors++; $display("FAIL rand_double_pulse seg %0d got 1 exp 0", seg); end
        prev = din_pulse;
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; raw_in = 1'b0; glitch_clr = 1'b0;
    m_q = 2'b00; m_level = 1'b0; m_run = 0; m_pulse = 1'b0; m_gcnt = 0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_saturation();
    test_reset_mid_debounce();
    test_chain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
